mux2_reg32: RTL and testbench
=============================

// Module: mux2_reg32
// PURPOSE
//   Two-input, WIDTH-bit data selector for the single-cycle processor datapath.
//   Typical uses: ALUSrc, MemToReg and RegDst style choices between two operands.
//   The output is registered, giving one cycle of latency, and a valid flag travels with the data.
//   A compile-time option turns the block into a purely combinational mux.
// PARAMETERS
//   WIDTH  32  data width of input0, input1 and out
// PORTS
//   clk       in   1      rising-edge clock
//   rst_n     in   1      reset, synchronous and active-low; sampled on the rising edge of clk
//   select    in   1      0 selects input0, 1 selects input1
//   input0    in   WIDTH  data operand 0
//   input1    in   WIDTH  data operand 1
//   in_valid  in   1      select/input0/input1 hold a valid sample this cycle
//   out       out  WIDTH  selected data
//   out_valid out  1      out holds a valid sample
// BEHAVIOUR
//   - Reset: when rst_n==0 at a rising clk edge, out<=0 and out_valid<=0 on that edge.
//     Reset has priority over every other input.
//   - Capture: on a rising edge with rst_n==1 and in_valid==1:
//     out<=(select ? input1 : input0); out_valid<=1.
//     Latency is exactly 1 cycle.
//   - Hold: on a rising edge with rst_n==1 and in_valid==0: out keeps its value; out_valid<=0.
//     out is not cleared in this case.
//   - No backpressure. A new sample is accepted every cycle, so back-to-back samples give
//     back-to-back outputs.
//   - Operands narrower than WIDTH are zero-extended by the instantiating logic; the block does
//     no sign extension.
//   - input0 == input1: out equals that value regardless of select.
//   - select X/Z (simulation only): out is assigned all-X.
//   - Reset asserted mid-stream: any sample presented in the same cycle is dropped.
//     The first valid sample after rst_n returns high appears one cycle after it is presented.
//   - No internal state beyond out and out_valid.
// CONFIGURATION
//   MUX2_COMB_OUT_EN defined:
//     - out = select ? input1 : input0 and out_valid = in_valid, both combinational.
//     - Zero latency; clk and rst_n are unused; no registers are inferred.
//   MUX2_COMB_OUT_EN undefined (default):
//     - Registered behaviour as described above.
// TESTING
//   Registered build unless stated; all values are 32-bit.
//   1. rst_n=0 for 2 cycles with in_valid=1, select=1, input1=0xFFFFFFFF
//      -> out=0x00000000 and out_valid=0 throughout.
//   2. select=0, input0=0x00000005, input1=0x00000005 (5'b00101 zero-extended), in_valid=1
//      -> next edge out=0x00000005, out_valid=1.
//   3. input0=0xAAAAAAAA, input1=0x55555555; select=0 then 1 on consecutive cycles, in_valid=1
//      -> out=0xAAAAAAAA, then 0x55555555, with no bubble.
//   4. After out=0x55555555, drop in_valid to 0 and change select and inputs
//      -> out stays 0x55555555, out_valid=0.
//   5. Assert rst_n=0 while a valid sample is presented -> sample dropped; out=0 next edge.
//   6. MUX2_COMB_OUT_EN build: select toggles 0->1 with input0=0x1, input1=0x2
//      -> out changes 0x1->0x2 in the same timestep, no clock edge needed.

Source files
------------

// File: rtl/mux2_reg32_if.sv
// Operand/result bundle for mux2_reg32: select, two operands, valid in; selected data, valid out.
interface mux2_reg32_if #(
    parameter int WIDTH = 32
);
    logic             select;
    logic [WIDTH-1:0] input0;
    logic [WIDTH-1:0] input1;
    logic             in_valid;
    logic [WIDTH-1:0] out;
    logic             out_valid;

    modport master (
        output select, input0, input1, in_valid,
        input  out, out_valid
    );

    modport slave (
        input  select, input0, input1, in_valid,
        output out, out_valid
    );
endinterface

// File: rtl/mux2_reg32.sv
// Two-input WIDTH-bit selector with registered output and travelling valid flag.
// Define MUX2_COMB_OUT_EN to build it as a purely combinational mux (clk/rst_n unused).
module mux2_reg32 #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mux2_reg32_if.slave   bus
);

    logic [WIDTH-1:0] w_sel;

    // An unknown select must not quietly merge the operands in simulation.
    always_comb begin
        w_sel = '0;
        case (bus.select)
            1'b0:    w_sel = bus.input0;
            1'b1:    w_sel = bus.input1;
            default: w_sel = 'x;
        endcase
    end

`ifdef MUX2_COMB_OUT_EN

    logic w_unused;
    assign w_unused      = ^{clk, rst_n};
    assign bus.out       = w_sel;
    assign bus.out_valid = bus.in_valid;

`else

    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;

    // Data holds when no sample arrives; only the valid flag drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid)
                r_out <= w_sel;
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;

`endif

endmodule

// File: tb/tb_mux2_reg32.sv
// Self-checking bench for mux2_reg32: directed cases plus randomized traffic against a reference model.
module tb_mux2_reg32;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [31:0] exp_out;
    logic        exp_valid;

    mux2_reg32_if #(.WIDTH(32)) bus ();

    mux2_reg32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifndef MUX2_COMB_OUT_EN

    // Present one cycle of inputs, let one rising edge pass, then advance the model.
    task automatic step(input bit rn, input bit v, input bit s,
                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] operands [2];
        rst_n        = rn;
        bus.in_valid = v;
        bus.select   = s;
        bus.input0   = a;
        bus.input1   = b;
        operands[0]  = a;
        operands[1]  = b;
        @(posedge clk);
        #1;
        if (!rn) begin
            exp_out   = 32'h0;
            exp_valid = 1'b0;
        end else begin
            if (v) exp_out = operands[s];
            exp_valid = v;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
            total++;
            if (bus.out !== 32'h0 || bus.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset cyc%0d: out=%h valid=%b required out=00000000 valid=0",
                         i, bus.out, bus.out_valid);
            end
        end
    endtask

    task automatic test_equal_inputs();
        step(1'b1, 1'b1, 1'b0, 32'h0000_0005, 32'h0000_0005);
        total++;
        if (bus.out !== 32'h0000_0005 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL equal_sel0: out=%h valid=%b required out=00000005 valid=1",
                     bus.out, bus.out_valid);
        end
        step(1'b1, 1'b1, 1'b1, 32'h0000_0005, 32'h0000_0005);
        total++;
        if (bus.out !== 32'h0000_0005 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL equal_sel1: out=%h valid=%b required out=00000005 valid=1",
                     bus.out, bus.out_valid);
        end
    endtask

    task automatic test_alternating();
        step(1'b1, 1'b1, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555);
        total++;
        if (bus.out !== 32'hAAAA_AAAA || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL alt_sel0: out=%h valid=%b required out=aaaaaaaa valid=1",
                     bus.out, bus.out_valid);
        end
        step(1'b1, 1'b1, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555);
        total++;
        if (bus.out !== 32'h5555_5555 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL alt_sel1: out=%h valid=%b required out=55555555 valid=1",
                     bus.out, bus.out_valid);
        end
    endtask

    task automatic test_hold();
        step(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        total++;
        if (bus.out !== 32'h5555_5555 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold0: out=%h valid=%b required out=55555555 valid=0",
                     bus.out, bus.out_valid);
        end
        step(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        total++;
        if (bus.out !== 32'h5555_5555 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold1: out=%h valid=%b required out=55555555 valid=0",
                     bus.out, bus.out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 1'b1, 1'b1, 32'h0, 32'hCAFE_0001);
        step(1'b0, 1'b1, 1'b1, 32'h0, 32'hCAFE_0002);
        total++;
        if (bus.out !== 32'h0 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: out=%h valid=%b required out=00000000 valid=0",
                     bus.out, bus.out_valid);
        end
        step(1'b1, 1'b1, 1'b0, 32'hCAFE_0003, 32'h0);
        total++;
        if (bus.out !== 32'hCAFE_0003 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: out=%h valid=%b required out=cafe0003 valid=1",
                     bus.out, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(1));
            step(1'b1, 1'b1, s, a, b);
            total++;
            if (bus.out !== (s ? b : a) || bus.out_valid !== 1'b1) begin
                bad++;
                $display("FAIL b2b[%0d]: out=%h valid=%b required out=%h valid=1",
                         i, bus.out, bus.out_valid, s ? b : a);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        bit          rn, v, s;
        for (int i = 0; i < 400; i++) begin
            rn = ($urandom_range(15) != 0);
            v  = 1'($urandom_range(1));
            s  = 1'($urandom_range(1));
            a  = $urandom;
            b  = ($urandom_range(7) == 0) ? a : $urandom;
            step(rn, v, s, a, b);
            total++;
            if (bus.out !== exp_out || bus.out_valid !== exp_valid) begin
                bad++;
                $display("FAIL random[%0d]: out=%h valid=%b required out=%h valid=%b",
                         i, bus.out, bus.out_valid, exp_out, exp_valid);
            end
        end
    endtask

`else

    task automatic test_comb();
        logic [31:0] a;
        logic [31:0] b;
        bit          v, s;
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.input0   = 32'h1;
        bus.input1   = 32'h2;
        bus.select   = 1'b0;
        #1;
        total++;
        if (bus.out !== 32'h1 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL comb_sel0: out=%h valid=%b required out=00000001 valid=1",
                     bus.out, bus.out_valid);
        end
        bus.select = 1'b1;
        #1;
        total++;
        if (bus.out !== 32'h2 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL comb_sel1: out=%h valid=%b required out=00000002 valid=1",
                     bus.out, bus.out_valid);
        end
        for (int i = 0; i < 50; i++) begin
            a = $urandom;
            b = $urandom;
            v = 1'($urandom_range(1));
            s = 1'($urandom_range(1));
            bus.input0   = a;
            bus.input1   = b;
            bus.in_valid = v;
            bus.select   = s;
            #1;
            total++;
            if (bus.out !== (s ? b : a) || bus.out_valid !== v) begin
                bad++;
                $display("FAIL comb_random[%0d]: out=%h valid=%b required out=%h valid=%b",
                         i, bus.out, bus.out_valid, s ? b : a, v);
            end
        end
    endtask

`endif

    initial begin
        total        = 0;
        bad          = 0;
        exp_out      = 32'h0;
        exp_valid    = 1'b0;
        rst_n        = 1'b0;
        bus.select   = 1'b0;
        bus.input0   = 32'h0;
        bus.input1   = 32'h0;
        bus.in_valid = 1'b0;
`ifdef MUX2_COMB_OUT_EN
        test_comb();
`else
        test_reset();
        test_equal_inputs();
        test_alternating();
        test_hold();
        test_reset_midstream();
        test_back_to_back();
        test_random();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
